// File: rtl/rv32_stim_gen.sv
// Random RV32I instruction stimulus generator: warm-up NOPs, then LFSR-driven
// R/I/load words with optional rs1 hazards drawn from recent destinations.
module rv32_stim_gen #(
  parameter logic [63:0] SEED          = 64'd737,
  parameter logic [2:0]  MODE_MASK     = 3'b001,
  parameter logic [4:0]  REG_MASK      = 5'h1F,
  parameter int          HIST_DEPTH    = 4,
  parameter int          WARMUP        = 3,
  parameter int          NUM_INSTR     = 100,
  parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF,
  localparam int         CNT_W         = (NUM_INSTR > 0) ? $clog2(NUM_INSTR + 1) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             hazard_en,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [2:0]  MM       = (MODE_MASK == 3'b000) ? 3'b001 : MODE_MASK;
  localparam int          WC_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_INSTR - 1);
  localparam logic [2:0]  HD       = 3'(HIST_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {K_R, K_I, K_L} kind_t;

  localparam kind_t K_LOW = MM[0] ? K_R : (MM[1] ? K_I : K_L);

  state_t           state_q, state_d;
  logic [63:0]      lfsr_q;
  logic [CNT_W-1:0] count_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [4:0]       hist_q [4];
  logic [2:0]       hist_cnt_q;
  logic             acc, start_ok;

  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [11:0] imm, imm_i;
  logic [1:0]  hidx;
  logic [6:0]  f7;
  kind_t       kind;
  logic [31:0] run_word;

  // Decode of the current LFSR state into one instruction word
  always_comb begin
    rs1  = lfsr_q[4:0]   & REG_MASK;
    rs2  = lfsr_q[9:5]   & REG_MASK;
    rd   = lfsr_q[14:10] & REG_MASK;
    f3   = lfsr_q[17:15];
    imm  = lfsr_q[29:18];
    hidx = 2'(32'(lfsr_q[34:33]) % HIST_DEPTH);
    if ({1'b0, hidx} >= hist_cnt_q) hidx = 2'(hist_cnt_q - 3'd1);
    if (hazard_en && lfsr_q[32] && (hist_cnt_q != 3'd0)) rs1 = hist_q[hidx];

    case (lfsr_q[31:30])
      2'd2:    kind = K_I;
      2'd3:    kind = K_L;
      default: kind = K_R;
    endcase
    if (!MM[kind]) kind = K_LOW;

    f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && imm[10]) ? 7'h20 : 7'h00;
    // Shift immediates keep only shamt plus the arithmetic-select bit
    case (f3)
      3'd5:    imm_i = imm & 12'h41F;
      3'd1:    imm_i = imm & 12'h01F;
      default: imm_i = imm;
    endcase

    case (kind)
      K_I:     run_word = {imm_i, rs1, f3, rd, 7'b0010011};
      K_L:     run_word = {imm & LOAD_IMM_MASK, rs1, f3 & 3'b100, rd, 7'b0000011};
      default: run_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
    endcase
  end

  always_comb begin
    instr       = NOP;
    instr_valid = 1'b0;
    case (state_q)
      S_WARMUP: instr_valid = 1'b1;
      S_RUN: begin
        instr_valid = 1'b1;
        instr       = run_word;
      end
      default: ;
    endcase
  end

  assign acc      = instr_valid & instr_ready;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign done     = (state_q == S_DONE);
  assign count    = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE:
        if (start)
          state_d = (WARMUP > 0) ? S_WARMUP : ((NUM_INSTR > 0) ? S_RUN : S_DONE);
      S_WARMUP:
        if (acc && (wcnt_q == WARM_LAST))
          state_d = (NUM_INSTR > 0) ? S_RUN : S_DONE;
      S_RUN:
        if (acc && (count_q == CNT_LAST)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // The LFSR is deliberately untouched by start so runs continue the sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      count_q    <= '0;
      wcnt_q     <= '0;
      hist_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        count_q    <= '0;
        wcnt_q     <= '0;
        hist_cnt_q <= '0;
      end else if (acc && (state_q == S_WARMUP)) begin
        wcnt_q <= wcnt_q + WC_W'(1);
      end else if (acc && (state_q == S_RUN)) begin
        count_q <= count_q + CNT_W'(1);
        lfsr_q  <= {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
        if (hist_cnt_q != HD) hist_cnt_q <= hist_cnt_q + 3'd1;
      end
    end
  end

  // History contents need no reset: hist_cnt_q gates every read
  always_ff @(posedge clk) begin
    if (acc && (state_q == S_RUN)) begin
      hist_q[0] <= rd;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
    end
  end
endmodule

// File: tb/tb_rv32_stim_gen.sv
// Bench for rv32_stim_gen: four parameterisations checked against a
// field-level reference model of the instruction generator.
module tb_rv32_stim_gen;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [63:0] SEED_C = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rdy;
  logic start_a, start_b, start_c, start_d;
  logic hz_a, hz_b, hz_c, hz_d;
  logic [31:0] instr_a, instr_b, instr_c, instr_d;
  logic vld_a, vld_b, vld_c, vld_d;
  logic done_a, done_b, done_c, done_d;
  logic [6:0] count_a;
  logic [9:0] count_b;
  logic [7:0] count_c;
  logic [0:0] count_d;

  rv32_stim_gen dut_a (.clk(clk), .reset_n(reset_n), .start(start_a), .hazard_en(hz_a),
    .instr_ready(rdy), .instr(instr_a), .instr_valid(vld_a), .count(count_a), .done(done_a));
  rv32_stim_gen #(.SEED(64'd0), .MODE_MASK(3'b110), .NUM_INSTR(1000)) dut_b (.clk(clk),
    .reset_n(reset_n), .start(start_b), .hazard_en(hz_b), .instr_ready(rdy), .instr(instr_b),
    .instr_valid(vld_b), .count(count_b), .done(done_b));
  rv32_stim_gen #(.SEED(SEED_C), .MODE_MASK(3'b111), .REG_MASK(5'h07), .HIST_DEPTH(2),
    .NUM_INSTR(200)) dut_c (.clk(clk), .reset_n(reset_n), .start(start_c), .hazard_en(hz_c),
    .instr_ready(rdy), .instr(instr_c), .instr_valid(vld_c), .count(count_c), .done(done_c));
  rv32_stim_gen #(.NUM_INSTR(0)) dut_d (.clk(clk), .reset_n(reset_n), .start(start_d),
    .hazard_en(hz_d), .instr_ready(rdy), .instr(instr_d), .instr_valid(vld_d), .count(count_d),
    .done(done_d));

  int errors = 0;
  int checks = 0;
  logic [63:0] ml_a;
  logic [31:0] run1 [100];
  logic [4:0]  h_none [4];

  function automatic logic [63:0] lfsr_next(input logic [63:0] L);
    return {L[62:0], L[63] ^ L[62] ^ L[60] ^ L[59]};
  endfunction

  function automatic logic [31:0] model_word(input logic [63:0] L, input logic [2:0] mode,
      input logic [4:0] rmask, input int hd, input logic [11:0] lmask, input bit hz,
      input logic [4:0] h [4], input int hc);
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3, mm;
    logic [11:0] imm;
    int cls, idx;
    rs1 = L[4:0] & rmask;
    rs2 = L[9:5] & rmask;
    rd  = L[14:10] & rmask;
    f3  = L[17:15];
    imm = L[29:18];
    mm  = (mode == 3'b000) ? 3'b001 : mode;
    cls = (L[31:30] == 2'd3) ? 2 : ((L[31:30] == 2'd2) ? 1 : 0);
    if (!mm[cls]) for (int k = 2; k >= 0; k--) if (mm[k]) cls = k;
    if (hz && L[32] && hc > 0) begin
      idx = int'(L[34:33]) % hd;
      if (idx > hc - 1) idx = hc - 1;
      rs1 = h[idx];
    end
    if (cls == 1) begin
      if (f3 == 3'd1) imm = imm & 12'h01F;
      else if (f3 == 3'd5) imm = imm & 12'h41F;
      return {imm, rs1, f3, rd, 7'b0010011};
    end
    if (cls == 2) return {imm & lmask, rs1, f3 & 3'b100, rd, 7'b0000011};
    return {(((f3 == 3'd0) || (f3 == 3'd5)) && imm[10]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (instr_a !== NOP || vld_a !== 1'b0 || count_a !== 7'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got instr=%h vld=%b count=%0d done=%b expected %h/0/0/0",
               instr_a, vld_a, count_a, done_a, NOP);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ml_a = 64'd737;
  endtask

  task automatic test_basic_run();
    int nacc = 0;
    int cyc = 0;
    logic [31:0] exp;
    @(negedge clk); start_a = 1'b1; rdy = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (nacc < 103 && cyc < 400) begin
      exp = (nacc < 3) ? NOP : model_word(ml_a, 3'b001, 5'h1F, 4, 12'hFFF, 1'b0, h_none, 0);
      checks++;
      if (vld_a !== 1'b1 || instr_a !== exp) begin
        errors++;
        $display("FAIL basic_word[%0d]: got vld=%b instr=%h expected vld=1 instr=%h", nacc, vld_a, instr_a, exp);
      end
      if (nacc >= 3) begin
        checks++;
        if (instr_a[6:0] !== 7'b0110011 || count_a !== 7'(nacc - 3) || done_a !== 1'b0) begin
          errors++;
          $display("FAIL basic_rtype[%0d]: got op=%b count=%0d done=%b expected op=0110011 count=%0d done=0",
                   nacc, instr_a[6:0], count_a, done_a, nacc - 3);
        end
        run1[nacc-3] = exp;
        ml_a = lfsr_next(ml_a);
      end
      nacc++;
      @(negedge clk); cyc++;
    end
    if (nacc < 103) begin
      errors++;
      $display("FAIL basic_timeout: got %0d acceptances expected 103", nacc);
    end
    checks++;
    if (done_a !== 1'b1 || count_a !== 7'd100 || vld_a !== 1'b0 || instr_a !== NOP) begin
      errors++;
      $display("FAIL basic_done: got done=%b count=%0d vld=%b instr=%h expected 1/100/0/%h",
               done_a, count_a, vld_a, instr_a, NOP);
    end
  endtask

  task automatic test_back_to_back();
    int nacc = 0;
    int cyc = 0;
    int held = 0;
    int same = 0;
    bit prev_stall = 0;
    logic [31:0] exp, prev_instr;
    logic [6:0] prev_cnt;
    @(negedge clk); start_a = 1'b1; rdy = 1'b0;
    @(negedge clk); start_a = 1'b0;
    while (nacc < 103 && cyc < 1500) begin
      if (prev_stall) begin
        checks++;
        if (instr_a !== prev_instr || count_a !== prev_cnt) begin
          errors++;
          $display("FAIL stall_hold: got instr=%h count=%0d expected instr=%h count=%0d",
                   instr_a, count_a, prev_instr, prev_cnt);
        end
      end
      exp = (nacc < 3) ? NOP : model_word(ml_a, 3'b001, 5'h1F, 4, 12'hFFF, 1'b0, h_none, 0);
      checks++;
      if (vld_a !== 1'b1 || instr_a !== exp) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got vld=%b instr=%h expected vld=1 instr=%h", nacc, vld_a, instr_a, exp);
      end
      start_a = (nacc == 60);
      if (nacc == 23 && held < 5) begin
        rdy = 1'b0;
        held++;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (rdy) begin
        if (nacc >= 3) begin
          if (exp == run1[nacc-3]) same++;
          ml_a = lfsr_next(ml_a);
        end
        nacc++;
      end
      prev_stall = !rdy;
      prev_instr = instr_a;
      prev_cnt = count_a;
      @(negedge clk); cyc++;
    end
    start_a = 1'b0;
    if (nacc < 103) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d acceptances expected 103", nacc);
    end
    checks++;
    if (done_a !== 1'b1 || count_a !== 7'd100) begin
      errors++;
      $display("FAIL b2b_done: got done=%b count=%0d expected 1/100", done_a, count_a);
    end
    checks++;
    if (same == 100) begin
      errors++;
      $display("FAIL b2b_differ: got %0d identical words expected fewer than 100", same);
    end
  endtask

  task automatic test_reset_midrun();
    int nacc = 0;
    int cyc = 0;
    logic [31:0] exp;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; rdy = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (nacc < 53 && cyc < 200) begin
      exp = (nacc < 3) ? NOP : run1[nacc-3];
      checks++;
      if (instr_a !== exp) begin
        errors++;
        $display("FAIL partial_word[%0d]: got %h expected %h", nacc, instr_a, exp);
      end
      nacc++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (count_a !== 7'd50) begin
      errors++;
      $display("FAIL partial_count: got %0d expected 50", count_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (instr_a !== NOP || vld_a !== 1'b0 || count_a !== 7'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got instr=%h vld=%b count=%0d done=%b expected %h/0/0/0",
               instr_a, vld_a, count_a, done_a, NOP);
    end
    @(negedge clk); reset_n = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    nacc = 0;
    cyc = 0;
    while (nacc < 103 && cyc < 400) begin
      exp = (nacc < 3) ? NOP : run1[nacc-3];
      checks++;
      if (vld_a !== 1'b1 || instr_a !== exp) begin
        errors++;
        $display("FAIL rerun_word[%0d]: got vld=%b instr=%h expected vld=1 instr=%h", nacc, vld_a, instr_a, exp);
      end
      nacc++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (done_a !== 1'b1 || count_a !== 7'd100) begin
      errors++;
      $display("FAIL rerun_done: got done=%b count=%0d expected 1/100", done_a, count_a);
    end
  endtask

  task automatic test_classes();
    logic [63:0] L = 64'd1;
    logic [4:0] h [4];
    int hc = 0;
    int nacc = 0;
    int cyc = 0;
    logic [31:0] exp;
    logic [6:0] op;
    logic [2:0] f3;
    foreach (h[i]) h[i] = 5'd0;
    @(negedge clk); start_b = 1'b1; rdy = 1'b0;
    @(negedge clk); start_b = 1'b0;
    while (nacc < 1003 && cyc < 3000) begin
      hz_b = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp = (nacc < 3) ? NOP : model_word(L, 3'b110, 5'h1F, 4, 12'hFFF, hz_b, h, hc);
      checks++;
      if (vld_b !== 1'b1 || instr_b !== exp) begin
        errors++;
        $display("FAIL class_word[%0d]: got vld=%b instr=%h expected vld=1 instr=%h", nacc, vld_b, instr_b, exp);
      end
      if (nacc >= 3) begin
        op = instr_b[6:0];
        f3 = instr_b[14:12];
        checks++;
        if (!(op == 7'b0010011 || op == 7'b0000011) ||
            (op == 7'b0010011 && f3 == 3'd1 && instr_b[31:25] != 7'd0) ||
            (op == 7'b0010011 && f3 == 3'd5 && (instr_b[31:20] & 12'hBE0) != 12'd0) ||
            (op == 7'b0000011 && f3 != 3'd0 && f3 != 3'd4)) begin
          errors++;
          $display("FAIL class_rules[%0d]: got instr=%h expected I/load with legal f3/imm", nacc, instr_b);
        end
      end
      if (rdy) begin
        if (nacc >= 3) begin
          for (int i = 3; i > 0; i--) h[i] = h[i-1];
          h[0] = L[14:10];
          if (hc < 4) hc++;
          L = lfsr_next(L);
        end
        nacc++;
      end
      @(negedge clk); cyc++;
    end
    hz_b = 1'b0;
    checks++;
    if (done_b !== 1'b1 || count_b !== 10'd1000) begin
      errors++;
      $display("FAIL class_done: got done=%b count=%0d expected 1/1000", done_b, count_b);
    end
  endtask

  task automatic test_hazard();
    logic [63:0] L = SEED_C;
    logic [4:0] h [4];
    int hc = 0;
    int nacc = 0;
    int cyc = 0;
    logic [31:0] exp;
    logic [4:0] obs0 = 5'd0;
    logic [4:0] obs1 = 5'd0;
    int obs_n = 0;
    foreach (h[i]) h[i] = 5'd0;
    hz_c = 1'b1;
    @(negedge clk); start_c = 1'b1; rdy = 1'b0;
    @(negedge clk); start_c = 1'b0;
    while (nacc < 203 && cyc < 1000) begin
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp = (nacc < 3) ? NOP : model_word(L, 3'b111, 5'h07, 2, 12'hFFF, 1'b1, h, hc);
      checks++;
      if (vld_c !== 1'b1 || instr_c !== exp) begin
        errors++;
        $display("FAIL hazard_word[%0d]: got vld=%b instr=%h expected vld=1 instr=%h", nacc, vld_c, instr_c, exp);
      end
      if (nacc >= 3) begin
        checks++;
        if (instr_c[11:7] >= 5'd8 || instr_c[19:15] >= 5'd8 ||
            (instr_c[6:0] == 7'b0110011 && instr_c[24:20] >= 5'd8)) begin
          errors++;
          $display("FAIL reg_range[%0d]: got instr=%h expected all register fields below 8", nacc, instr_c);
        end
        if (L[32] && hc > 0) begin
          checks++;
          if (!(instr_c[19:15] == obs0 || (obs_n > 1 && instr_c[19:15] == obs1))) begin
            errors++;
            $display("FAIL hazard_src[%0d]: got rs1=%0d expected one of %0d/%0d", nacc, instr_c[19:15], obs0, obs1);
          end
        end
      end
      if (rdy) begin
        if (nacc >= 3) begin
          obs1 = obs0;
          obs0 = instr_c[11:7];
          obs_n++;
          for (int i = 3; i > 0; i--) h[i] = h[i-1];
          h[0] = L[14:10] & 5'h07;
          if (hc < 2) hc++;
          L = lfsr_next(L);
        end
        nacc++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (done_c !== 1'b1 || count_c !== 8'd200) begin
      errors++;
      $display("FAIL hazard_done: got done=%b count=%0d expected 1/200", done_c, count_c);
    end
  endtask

  task automatic test_zero_instr();
    @(negedge clk); start_d = 1'b1; rdy = 1'b1;
    @(negedge clk); start_d = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (vld_d !== 1'b1 || instr_d !== NOP || done_d !== 1'b0) begin
        errors++;
        $display("FAIL zero_warmup[%0d]: got vld=%b instr=%h done=%b expected 1/%h/0", n, vld_d, instr_d, done_d, NOP);
      end
      @(negedge clk);
    end
    checks++;
    if (done_d !== 1'b1 || count_d !== 1'b0 || vld_d !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b count=%0d vld=%b expected 1/0/0", done_d, count_d, vld_d);
    end
  endtask

  initial begin
    rdy = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    hz_a = 1'b0; hz_b = 1'b0; hz_c = 1'b0; hz_d = 1'b0;
    foreach (h_none[i]) h_none[i] = 5'd0;
    test_reset();
    test_basic_run();
    test_back_to_back();
    test_reset_midrun();
    test_classes();
    test_hazard();
    test_zero_instr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32_stim_gen.md
RV32_STIM_GEN -- requirements
Module: rv32_stim_gen

Interface
REQ-001 Parameter SEED, default 64'd737, SHALL set the initial 64-bit LFSR state; a value of 0 SHALL be replaced by 1.
REQ-002 Parameter MODE_MASK, default 3'b001, SHALL enable instruction classes: bit0 R-type, bit1 I-type ALU, bit2 load.
REQ-003 Parameter REG_MASK, default 5'h1F, SHALL be ANDed into every generated rs1/rs2/rd field.
REQ-004 Parameter HIST_DEPTH, default 4, range 1..4, SHALL set the destination-register history depth for hazard injection.
REQ-005 Parameter WARMUP, default 3, SHALL set the number of NOPs emitted before random instructions.
REQ-006 Parameter NUM_INSTR, default 100, SHALL set the number of random instructions per run; CNT_W = clog2(NUM_INSTR+1).
REQ-007 Parameter LOAD_IMM_MASK, default 12'hFFF, SHALL be ANDed into load immediates.
REQ-008 clk  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  one-cycle pulse; starts a run from IDLE or DONE.
REQ-011 hazard_en  in  1  enables rs1 substitution from the rd history.
REQ-012 instr_ready  in  1  consumer accepts instr this cycle.
REQ-013 instr  out  32  instruction word.
REQ-014 instr_valid  out  1  instr is valid.
REQ-015 count  out  CNT_W  random instructions accepted this run.
REQ-016 done  out  1  run complete.

Function
REQ-017 The FSM SHALL have states IDLE, WARMUP, RUN, DONE; start in IDLE/DONE -> WARMUP, clearing count, the warm-up counter and the history; start in other states SHALL be ignored.
REQ-018 In IDLE and DONE, instr SHALL be 32'h00000013 and instr_valid SHALL be 0.
REQ-019 In WARMUP, instr SHALL be 32'h00000013 with instr_valid=1; each accepted word (valid&&ready) SHALL increment the warm-up counter; after WARMUP acceptances -> RUN; WARMUP=0 SHALL go directly to RUN.
REQ-020 In RUN, instr_valid SHALL be 1 and instr SHALL be decoded combinationally from the current LFSR state L; instr SHALL hold stable while instr_ready=0.
REQ-021 The LFSR SHALL be Fibonacci, polynomial x^64+x^63+x^61+x^60+1, and SHALL advance exactly one step per accepted RUN instruction, never otherwise.
REQ-022 Fields: rs1=L[4:0], rs2=L[9:5], rd=L[14:10], each &REG_MASK; f3=L[17:15]; imm=L[29:18]; class=L[31:30]; hz=L[32]; hidx=L[34:33] mod HIST_DEPTH.
REQ-023 class 0/1 -> R, 2 -> I, 3 -> load; a disabled class SHALL fall back to the lowest enabled class; MODE_MASK=0 SHALL be treated as 3'b001.
REQ-024 R-type: {f7, rs2, rs1, f3, rd, 7'b0110011}; f7=7'h20 when f3 in {0,5} and imm[10]=1, else 7'h00.
REQ-025 I-type: {imm', rs1, f3, rd, 7'b0010011}; imm'=imm&12'h41F for f3=5, imm&12'h01F for f3=1, else imm.
REQ-026 Load: {imm&LOAD_IMM_MASK, rs1, f3&3'b100, rd, 7'b0000011} (LB or LBU only).
REQ-027 When hazard_en=1 and hz=1 and history holds at least one entry, rs1 SHALL be replaced by history[hidx], hidx clamped to valid entries; R-type rs2 SHALL be unaffected.
REQ-028 History SHALL be a shift register of the last HIST_DEPTH accepted RUN rd values, newest at index 0; rd=0 SHALL also be recorded.
REQ-029 count SHALL increment on each RUN acceptance; on the acceptance making count==NUM_INSTR -> DONE, with done=1 from the next cycle until start or reset.
REQ-030 NUM_INSTR=0 SHALL go WARMUP -> DONE, skipping RUN.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, LFSR=SEED, count=0, warm-up counter=0, history empty, done=0, instr_valid=0, instr=32'h00000013, including mid-run.
REQ-032 The LFSR SHALL NOT reset on start; consecutive runs continue the sequence.

Verification
REQ-033 Reset, start, instr_ready=1 -> 3 NOPs (32'h00000013), then 100 valid R-type words (opcode 7'b0110011), done=1 and count=100 one cycle after the 100th.
REQ-034 instr_ready=0 for 5 cycles mid-RUN -> instr constant, count and LFSR unchanged; resumes same word when ready.
REQ-035 MODE_MASK=3'b110, 1000 instrs -> only opcodes 0010011/0000011; every f3=1 imm[11:5]=0, f3=5 imm&12'hBE0=0, load f3 in {0,4}.
REQ-036 REG_MASK=5'h07, hazard_en=1, HIST_DEPTH=2 -> all register fields <8; every rs1 substituted from history equals one of the last 2 accepted rd.
REQ-037 reset_n=0 asserted at count=50 -> outputs at reset values asynchronously; after reset+start, sequence identical to REQ-033 first run.
REQ-038 Two back-to-back runs without reset -> second run's words differ from first; NUM_INSTR=0 -> done after WARMUP with count=0.
